cdb_arbiter: RTL and testbench

- Shares the single ROB result-write port between the two completion sources: EX (ALU/branch) and SLB (load data).
- Each source pushes results into its own small FIFO. A round-robin scheduler pops one entry per cycle onto a registered common-data-bus (CDB).
- The CDB drives the ROB iEX_* result inputs and the RS/SLB operand-wakeup broadcast.
- Removes the same-cycle dual-write hazard on ROB dt/commit.

---
 rtl/cdb_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Shares the single ROB result-write port between the EX (ALU/branch) and
//   SLB (load) completion sources. Each source pushes into its own FIFO. A
//   round-robin scheduler pops at most one entry per cycle onto a registered
//   common data bus (CDB). The CDB feeds the ROB result inputs and the RS/SLB
//   wakeup broadcast, so the ROB never sees two writes in the same cycle.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   rdy                   global ready; 0 freezes every register
//   iclr                  mispredict flush (empties both FIFOs, kills the CDB)
//   iEX_*  / oEX_ready    EX result push interface (tag, data, outcome, target)
//   iSLB_* / oSLB_ready   load result push interface (tag, data)
//   oCDB_*                registered broadcast; oCDB_src 0 = EX, 1 = SLB
//
// Optional build macro
//   CDB_PERF_CNT_EN       adds oPERF_conflict and oPERF_full_stall counters
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned NICK_W     = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              iclr,
  input  logic              iEX_en,
  input  logic [NICK_W-1:0] iEX_nick,
  input  logic [DATA_W-1:0] iEX_dt,
  input  logic              iEX_ac,
  input  logic [ADDR_W-1:0] iEX_j_pc,
  output logic              oEX_ready,
  input  logic              iSLB_en,
  input  logic [NICK_W-1:0] iSLB_nick,
  input  logic [DATA_W-1:0] iSLB_dt,
  output logic              oSLB_ready,
  output logic              oCDB_en,
  output logic [NICK_W-1:0] oCDB_nick,
  output logic [DATA_W-1:0] oCDB_dt,
  output logic              oCDB_ac,
  output logic [ADDR_W-1:0] oCDB_j_pc,
  output logic              oCDB_src
`ifdef CDB_PERF_CNT_EN
  ,
  output logic [31:0]       oPERF_conflict,
  output logic [31:0]       oPERF_full_stall
`endif
);

  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned EXW  = NICK_W + DATA_W + 1 + ADDR_W;
  localparam int unsigned SLBW = NICK_W + DATA_W;

  typedef enum logic {
    SRC_EX  = 1'b0,
    SRC_SLB = 1'b1
  } src_e;

  // FIFO storage (no reset needed: validity is tracked by the counts)
  logic [EXW-1:0]  r_ex_mem  [FIFO_DEPTH];
  logic [SLBW-1:0] r_slb_mem [FIFO_DEPTH];

  logic [PW-1:0] r_ex_wptr, r_ex_rptr, r_slb_wptr, r_slb_rptr;
  logic [CW-1:0] r_ex_cnt, r_slb_cnt;
  src_e          r_rr_last;

  logic              w_ex_ne, w_slb_ne;
  logic              w_grant_ex, w_grant_slb;
  logic              w_ex_push, w_slb_push;
  logic              w_ex_pop, w_slb_pop;
  logic [EXW-1:0]    w_ex_head;
  logic [SLBW-1:0]   w_slb_head;

  assign oEX_ready  = (r_ex_cnt  < CW'(FIFO_DEPTH));
  assign oSLB_ready = (r_slb_cnt < CW'(FIFO_DEPTH));

  assign w_ex_ne  = (r_ex_cnt  != '0);
  assign w_slb_ne = (r_slb_cnt != '0);

  // EX wins when it is alone, or on a tie when SLB was granted last.
  always_comb begin
    w_grant_ex  = 1'b0;
    w_grant_slb = 1'b0;
    if (w_ex_ne && (!w_slb_ne || (r_rr_last == SRC_SLB))) begin
      w_grant_ex = 1'b1;
    end else if (w_slb_ne) begin
      w_grant_slb = 1'b1;
    end
  end

  // A tag-0 push completes the handshake but is not stored.
  assign w_ex_push  = rdy && !iclr && iEX_en  && oEX_ready  && (iEX_nick  != '0);
  assign w_slb_push = rdy && !iclr && iSLB_en && oSLB_ready && (iSLB_nick != '0);
  assign w_ex_pop   = rdy && !iclr && w_grant_ex;
  assign w_slb_pop  = rdy && !iclr && w_grant_slb;

  assign w_ex_head  = r_ex_mem[r_ex_rptr];
  assign w_slb_head = r_slb_mem[r_slb_rptr];

  always_ff @(posedge clk) begin
    if (w_ex_push) begin
      r_ex_mem[r_ex_wptr] <= {iEX_nick, iEX_dt, iEX_ac, iEX_j_pc};
    end
    if (w_slb_push) begin
      r_slb_mem[r_slb_wptr] <= {iSLB_nick, iSLB_dt};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_wptr  <= '0;
      r_ex_rptr  <= '0;
      r_ex_cnt   <= '0;
      r_slb_wptr <= '0;
      r_slb_rptr <= '0;
      r_slb_cnt  <= '0;
    end else if (iclr) begin
      r_ex_wptr  <= '0;
      r_ex_rptr  <= '0;
      r_ex_cnt   <= '0;
      r_slb_wptr <= '0;
      r_slb_rptr <= '0;
      r_slb_cnt  <= '0;
    end else begin
      // push/pop already include rdy, so nothing moves while rdy=0
      if (w_ex_push)  r_ex_wptr  <= r_ex_wptr  + PW'(1);
      if (w_ex_pop)   r_ex_rptr  <= r_ex_rptr  + PW'(1);
      if (w_slb_push) r_slb_wptr <= r_slb_wptr + PW'(1);
      if (w_slb_pop)  r_slb_rptr <= r_slb_rptr + PW'(1);
      case ({w_ex_push, w_ex_pop})
        2'b10:   r_ex_cnt <= r_ex_cnt + CW'(1);
        2'b01:   r_ex_cnt <= r_ex_cnt - CW'(1);
        default: r_ex_cnt <= r_ex_cnt;
      endcase
      case ({w_slb_push, w_slb_pop})
        2'b10:   r_slb_cnt <= r_slb_cnt + CW'(1);
        2'b01:   r_slb_cnt <= r_slb_cnt - CW'(1);
        default: r_slb_cnt <= r_slb_cnt;
      endcase
    end
  end

  // The round-robin pointer only moves on a real conflict, so a lone source
  // does not lose its place in the next tie. Flush leaves it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_last <= SRC_SLB;
    end else if (rdy && !iclr && w_ex_ne && w_slb_ne) begin
      r_rr_last <= w_grant_ex ? SRC_EX : SRC_SLB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oCDB_en   <= 1'b0;
      oCDB_nick <= '0;
      oCDB_dt   <= '0;
      oCDB_ac   <= 1'b0;
      oCDB_j_pc <= '0;
      oCDB_src  <= 1'b0;
    end else if (iclr) begin
      oCDB_en   <= 1'b0;
      oCDB_nick <= '0;
      oCDB_dt   <= '0;
      oCDB_ac   <= 1'b0;
      oCDB_j_pc <= '0;
      oCDB_src  <= 1'b0;
    end else if (rdy) begin
      if (w_ex_pop) begin
        oCDB_en                                    <= 1'b1;
        {oCDB_nick, oCDB_dt, oCDB_ac, oCDB_j_pc}   <= w_ex_head;
        oCDB_src                                   <= SRC_EX;
      end else if (w_slb_pop) begin
        oCDB_en              <= 1'b1;
        {oCDB_nick, oCDB_dt} <= w_slb_head;
        oCDB_ac              <= 1'b0;
        oCDB_j_pc            <= '0;
        oCDB_src             <= SRC_SLB;
      end else begin
        oCDB_en   <= 1'b0;
        oCDB_nick <= '0;
        oCDB_dt   <= '0;
        oCDB_ac   <= 1'b0;
        oCDB_j_pc <= '0;
        oCDB_src  <= 1'b0;
      end
    end
  end

`ifdef CDB_PERF_CNT_EN
  logic [31:0] r_perf_conflict;
  logic [31:0] r_perf_full_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_conflict   <= '0;
      r_perf_full_stall <= '0;
    end else if (rdy) begin
      if (!iclr && w_ex_ne && w_slb_ne) begin
        r_perf_conflict <= r_perf_conflict + 32'd1;
      end
      if ((iEX_en && !oEX_ready) || (iSLB_en && !oSLB_ready)) begin
        r_perf_full_stall <= r_perf_full_stall + 32'd1;
      end
    end
  end

  assign oPERF_conflict   = r_perf_conflict;
  assign oPERF_full_stall = r_perf_full_stall;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//   Self-checking bench for cdb_arbiter. A queue-based reference model predicts
//   each broadcast and pushes it into a scoreboard; a monitor on the falling
//   edge pops and compares whenever the DUT presents a new CDB entry.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned NW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;

  typedef struct packed {
    logic          src;
    logic [NW-1:0] nick;
    logic [DW-1:0] dt;
    logic          ac;
    logic [AW-1:0] jpc;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rdy;
  logic          iclr;
  logic          iEX_en;
  logic [NW-1:0] iEX_nick;
  logic [DW-1:0] iEX_dt;
  logic          iEX_ac;
  logic [AW-1:0] iEX_j_pc;
  logic          oEX_ready;
  logic          iSLB_en;
  logic [NW-1:0] iSLB_nick;
  logic [DW-1:0] iSLB_dt;
  logic          oSLB_ready;
  logic          oCDB_en;
  logic [NW-1:0] oCDB_nick;
  logic [DW-1:0] oCDB_dt;
  logic          oCDB_ac;
  logic [AW-1:0] oCDB_j_pc;
  logic          oCDB_src;
`ifdef CDB_PERF_CNT_EN
  logic [31:0]   oPERF_conflict;
  logic [31:0]   oPERF_full_stall;
`endif

  always #5 clk = ~clk;

  cdb_arbiter #(
    .FIFO_DEPTH (DEPTH),
    .NICK_W     (NW),
    .DATA_W     (DW),
    .ADDR_W     (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rdy        (rdy),
    .iclr       (iclr),
    .iEX_en     (iEX_en),
    .iEX_nick   (iEX_nick),
    .iEX_dt     (iEX_dt),
    .iEX_ac     (iEX_ac),
    .iEX_j_pc   (iEX_j_pc),
    .oEX_ready  (oEX_ready),
    .iSLB_en    (iSLB_en),
    .iSLB_nick  (iSLB_nick),
    .iSLB_dt    (iSLB_dt),
    .oSLB_ready (oSLB_ready),
    .oCDB_en    (oCDB_en),
    .oCDB_nick  (oCDB_nick),
    .oCDB_dt    (oCDB_dt),
    .oCDB_ac    (oCDB_ac),
    .oCDB_j_pc  (oCDB_j_pc),
    .oCDB_src   (oCDB_src)
`ifdef CDB_PERF_CNT_EN
    ,
    .oPERF_conflict   (oPERF_conflict),
    .oPERF_full_stall (oPERF_full_stall)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  ent_t        exq[$];
  ent_t        slbq[$];
  ent_t        sbq[$];
  bit          m_rr;       // 1: SLB was granted last in a conflict
  bit          m_en;
  int unsigned m_conflict;
  int unsigned m_stall;

  always @(posedge clk or negedge rst_n) begin
    ent_t e;
    bit   ex_full, slb_full;
    if (!rst_n) begin
      exq.delete();
      slbq.delete();
      sbq.delete();
      m_rr       = 1'b1;
      m_en       = 1'b0;
      m_conflict = 0;
      m_stall    = 0;
    end else begin
      ex_full  = (exq.size()  >= DEPTH);
      slb_full = (slbq.size() >= DEPTH);
      if (rdy && ((iEX_en && ex_full) || (iSLB_en && slb_full))) m_stall++;
      if (iclr) begin
        exq.delete();
        slbq.delete();
        m_en = 1'b0;
      end else if (rdy) begin
        if (exq.size() > 0 && slbq.size() > 0) m_conflict++;
        if (exq.size() > 0 && (slbq.size() == 0 || m_rr)) begin
          if (slbq.size() > 0) m_rr = 1'b0;
          sbq.push_back(exq.pop_front());
          m_en = 1'b1;
        end else if (slbq.size() > 0) begin
          if (exq.size() > 0) m_rr = 1'b1;
          sbq.push_back(slbq.pop_front());
          m_en = 1'b1;
        end else begin
          m_en = 1'b0;
        end
        if (iEX_en && !ex_full && iEX_nick != 0) begin
          e = '{src: 1'b0, nick: iEX_nick, dt: iEX_dt, ac: iEX_ac, jpc: iEX_j_pc};
          exq.push_back(e);
        end
        if (iSLB_en && !slb_full && iSLB_nick != 0) begin
          e = '{src: 1'b1, nick: iSLB_nick, dt: iSLB_dt, ac: 1'b0, jpc: '0};
          slbq.push_back(e);
        end
      end
    end
  end

  // ---------------- monitor ----------------
  bit   edge_load;   // DUT was allowed to load the CDB at the last rising edge
  ent_t cur;

  always @(posedge clk) edge_load = rdy && !iclr;

  always @(negedge clk) begin
    if (rst_n) begin
      check("ex_ready",  64'(oEX_ready),  64'(exq.size()  < DEPTH));
      check("slb_ready", 64'(oSLB_ready), 64'(slbq.size() < DEPTH));
      check("cdb_en",    64'(oCDB_en),    64'(m_en));
      if (oCDB_en && edge_load) begin
        n_checks++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL sb_spurious: got nick %0h expected no broadcast at t=%0t", oCDB_nick, $time);
        end else begin
          cur = sbq.pop_front();
        end
      end
      if (oCDB_en) begin
        check("cdb_nick", 64'(oCDB_nick), 64'(cur.nick));
        check("cdb_dt",   64'(oCDB_dt),   64'(cur.dt));
        check("cdb_ac",   64'(oCDB_ac),   64'(cur.ac));
        check("cdb_jpc",  64'(oCDB_j_pc), 64'(cur.jpc));
        check("cdb_src",  64'(oCDB_src),  64'(cur.src));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic ee, input logic [NW-1:0] en_, input logic [DW-1:0] ed,
                      input logic ea, input logic [AW-1:0] ej,
                      input logic se, input logic [NW-1:0] sn, input logic [DW-1:0] sd,
                      input logic r, input logic c);
    iEX_en    = ee;
    iEX_nick  = en_;
    iEX_dt    = ed;
    iEX_ac    = ea;
    iEX_j_pc  = ej;
    iSLB_en   = se;
    iSLB_nick = sn;
    iSLB_dt   = sd;
    rdy       = r;
    iclr      = c;
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(0, '0, '0, 0, '0, 0, '0, '0, 1, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"},    64'(oCDB_en),    64'(0));
    check({tag, "_nick"},  64'(oCDB_nick),  64'(0));
    check({tag, "_dt"},    64'(oCDB_dt),    64'(0));
    check({tag, "_ac"},    64'(oCDB_ac),    64'(0));
    check({tag, "_jpc"},   64'(oCDB_j_pc),  64'(0));
    check({tag, "_src"},   64'(oCDB_src),   64'(0));
    check({tag, "_exrdy"}, 64'(oEX_ready),  64'(1));
    check({tag, "_slrdy"}, 64'(oSLB_ready), 64'(1));
  endtask

  initial begin
    rst_n = 1'b0;
    rdy = 1'b1; iclr = 1'b0;
    iEX_en = 1'b0; iEX_nick = '0; iEX_dt = '0; iEX_ac = 1'b0; iEX_j_pc = '0;
    iSLB_en = 1'b0; iSLB_nick = '0; iSLB_dt = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // single EX entry
    step(1, 5'd3, 32'h11, 1, 32'h100, 0, '0, '0, 1, 0);
    idle(2);
    // simultaneous EX and SLB
    step(1, 5'd4, 32'h44, 0, 32'h200, 1, 5'd5, 32'h55, 1, 0);
    idle(3);
    // EX back-to-back
    step(1, 5'd1, 32'hA1, 0, 32'h10, 0, '0, '0, 1, 0);
    step(1, 5'd2, 32'hA2, 1, 32'h20, 0, '0, '0, 1, 0);
    step(1, 5'd3, 32'hA3, 0, 32'h30, 0, '0, '0, 1, 0);
    idle(3);
    // both sources pushing continuously: FIFOs fill and grants alternate
    for (int unsigned i = 0; i < 12; i++)
      step(1, NW'(8 + i), 32'hE00 + i, i[0], 32'h400 + i, 1, NW'(20 + i), 32'h500 + i, 1, 0);
    // flush with a same-cycle SLB push of tag 7
    step(0, '0, '0, 0, '0, 1, 5'd7, 32'h77, 1, 1);
    idle(4);
    // tag 0 is accepted but never broadcast
    step(0, '0, '0, 0, '0, 1, 5'd0, 32'hFF, 1, 0);
    idle(2);
    // rdy low with a pending entry
    step(1, 5'd12, 32'hC12, 1, 32'h600, 0, '0, '0, 1, 0);
    for (int unsigned i = 0; i < 3; i++) step(0, '0, '0, 0, '0, 0, '0, '0, 0, 0);
    idle(3);
    // rdy low while an entry is already on the CDB
    step(0, '0, '0, 0, '0, 1, 5'd9, 32'h99, 1, 0);
    step(0, '0, '0, 0, '0, 0, '0, '0, 1, 0);
    for (int unsigned i = 0; i < 3; i++) step(0, '0, '0, 0, '0, 0, '0, '0, 0, 0);
    idle(2);

    // randomized traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, NW'($urandom_range(0, 31)), $urandom, 1'($urandom),
           $urandom, $urandom_range(0, 2) != 0, NW'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0);
    end
    idle(4);

    // asynchronous reset in the middle of traffic
    step(1, 5'd13, 32'hD13, 0, 32'h700, 1, 5'd14, 32'hD14, 1, 0);
    step(1, 5'd15, 32'hD15, 1, 32'h800, 1, 5'd16, 32'hD16, 1, 0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);

    check("sb_drain", 64'(sbq.size()), 64'(0));
`ifdef CDB_PERF_CNT_EN
    check("perf_conflict", 64'(oPERF_conflict),   64'(m_conflict));
    check("perf_stall",    64'(oPERF_full_stall), 64'(m_stall));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
